// File: rtl/fifo_sram_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sram_pkg
// Shared definitions for the UART-FIFO to async-SRAM drain path:
//   - state_e : FSM state encoding shared by the top level and the write-cycle
//               sequencer
//   - DATA_W  : SRAM data width (one word = two bytes)
//   - BYTE_W  : FIFO byte width
// -----------------------------------------------------------------------------
package fifo_sram_pkg;

  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    SETUP,
    WRITE,
    HOLD
  } state_e;

endpackage : fifo_sram_pkg

// File: rtl/sram_wr_cycle.sv
// -----------------------------------------------------------------------------
// sram_wr_cycle
// Sequences one asynchronous-SRAM write: SETUP (ce low, we high), WRITE_CYCLES
// cycles of WRITE (ce and we low), then HOLD (we high, ce low). The byte lanes
// requested at start are held for the whole cycle and released after HOLD.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request; accepted only while idle
//   ub_n_in, lb_n_in    byte-lane enables (active low) for this write
//   done                high during the HOLD cycle
//   sram_ce_n/we_n      chip enable / write enable (active low)
//   sram_ub_n/lb_n      upper/lower byte enables (active low)
// -----------------------------------------------------------------------------
module sram_wr_cycle
  import fifo_sram_pkg::*;
#(
  parameter int WE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ub_n_in,
  input  logic lb_n_in,
  output logic done,
  output logic sram_ce_n,
  output logic sram_we_n,
  output logic sram_ub_n,
  output logic sram_lb_n
);

  localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ub_n_q, ub_n_d;
  logic             lb_n_q, lb_n_d;

  // NOTE: sequential state uses non-blocking assignments only; combinational
  // logic computes the *_d values with blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ub_n_d  = ub_n_q;
    lb_n_d  = lb_n_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          ub_n_d  = ub_n_in;
          lb_n_d  = lb_n_in;
        end
      end
      SETUP: begin
        state_d = WRITE;
        cnt_d   = CNT_W'(WE_CYCLES - 1);
      end
      WRITE: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      HOLD: begin
        state_d = IDLE;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state register so an asynchronous reset
  // releases ce_n/we_n in the same cycle rather than one edge later.
  assign done      = (state_q == HOLD);
  assign sram_ce_n = !(state_q inside {SETUP, WRITE, HOLD});
  assign sram_we_n = (state_q != WRITE);
  assign sram_ub_n = ub_n_q;
  assign sram_lb_n = lb_n_q;

endmodule : sram_wr_cycle

// File: rtl/fifo_sram_writer.sv
// -----------------------------------------------------------------------------
// fifo_sram_writer
// Paced drain of the UART receive FIFO into asynchronous SRAM. Each rising
// edge of pace pops at most one byte; byte pairs are packed little-endian into
// 16-bit words and written at an auto-incrementing word address. flush commits
// a dangling low byte as a lower-lane-only write with a zero upper byte.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pace                  pacing strobe (rising edge used)
//   flush                 commit a pending low byte
//   fifo_empty, fifo_dout FIFO status / read data (valid the cycle after pop)
//   fifo_rd_en            one-cycle pop request
//   sram_addr, sram_dq_o  word address / write data
//   sram_ce_n .. lb_n     active-low SRAM controls (oe_n tied inactive)
//   busy                  FSM not in IDLE
//   wrap                  one-cycle pulse when the address wraps to 0
//   words_written         completed writes, saturating
// -----------------------------------------------------------------------------
module fifo_sram_writer
  import fifo_sram_pkg::*;
#(
  parameter int                ADDR_W    = 23,
  parameter int                WE_CYCLES = 4,
  parameter logic [ADDR_W-1:0] MAX_ADDR  = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pace,
  input  logic              flush,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_dout,
  output logic              fifo_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic              busy,
  output logic              wrap,
  output logic [31:0]       words_written
);

  // SETUP is used here as "write cycle in flight"; the sequencer walks the
  // actual SETUP/WRITE/HOLD phases and reports done from its HOLD cycle.
  state_e              state_q, state_d;
  logic                pace_q;
  logic                lo_valid_q, lo_valid_d;
  logic [BYTE_W-1:0]   lo_byte_q, lo_byte_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dq_q, dq_d;
  logic                wrap_q, wrap_d;
  logic [31:0]         words_q, words_d;
  logic                pace_edge;
  logic                wr_start, wr_ub_n, wr_lb_n, wr_done;

  // pace_q resets high so a strobe already high when reset releases is not
  // mistaken for a rising edge.
  assign pace_edge = pace & ~pace_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pace_q     <= 1'b1;
      lo_valid_q <= 1'b0;
      lo_byte_q  <= '0;
      addr_q     <= '0;
      dq_q       <= '0;
      wrap_q     <= 1'b0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      pace_q     <= pace;
      lo_valid_q <= lo_valid_d;
      lo_byte_q  <= lo_byte_d;
      addr_q     <= addr_d;
      dq_q       <= dq_d;
      wrap_q     <= wrap_d;
      words_q    <= words_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lo_valid_d = lo_valid_q;
    lo_byte_d  = lo_byte_q;
    addr_d     = addr_q;
    dq_d       = dq_q;
    wrap_d     = 1'b0;
    words_d    = words_q;
    wr_start   = 1'b0;
    wr_ub_n    = 1'b1;
    wr_lb_n    = 1'b1;
    case (state_q)
      IDLE: begin
        // A pace edge wins over flush; edges seen in any other state are dropped.
        if (pace_edge && !fifo_empty) begin
          state_d = POP;
        end else if (flush && lo_valid_q) begin
          dq_d       = {{BYTE_W{1'b0}}, lo_byte_q};
          lo_valid_d = 1'b0;
          wr_start   = 1'b1;
          wr_lb_n    = 1'b0;
          state_d    = SETUP;
        end
      end
      POP: state_d = LATCH;
      LATCH: begin
        if (!lo_valid_q) begin
          lo_byte_d  = fifo_dout;
          lo_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          dq_d       = {fifo_dout, lo_byte_q};
          lo_valid_d = 1'b0;
          wr_start   = 1'b1;
          wr_ub_n    = 1'b0;
          wr_lb_n    = 1'b0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (wr_done) begin
          state_d = IDLE;
          if (addr_q == MAX_ADDR) begin
            addr_d = '0;
            wrap_d = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
          if (words_q != '1) words_d = words_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sram_wr_cycle #(
    .WE_CYCLES (WE_CYCLES)
  ) u_wr_cycle (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (wr_start),
    .ub_n_in   (wr_ub_n),
    .lb_n_in   (wr_lb_n),
    .done      (wr_done),
    .sram_ce_n (sram_ce_n),
    .sram_we_n (sram_we_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n)
  );

  assign fifo_rd_en    = (state_q == POP);
  assign busy          = (state_q != IDLE);
  assign sram_oe_n     = 1'b1;
  assign sram_addr     = addr_q;
  assign sram_dq_o     = dq_q;
  assign wrap          = wrap_q;
  assign words_written = words_q;

endmodule : fifo_sram_writer

// File: tb/tb_fifo_sram_writer.sv
// -----------------------------------------------------------------------------
// tb_fifo_sram_writer
// Self-checking bench for fifo_sram_writer with a 2-bit address so wrap-around
// is reachable. A behavioural model (byte queue, pending-byte flag, address
// counter) predicts every SRAM write when stimulus is issued; a monitor watches
// the SRAM bus and compares each completed write against the expected queue.
// -----------------------------------------------------------------------------
module tb_fifo_sram_writer;

  localparam int ADDR_W    = 2;
  localparam int WE_CYCLES = 4;
  localparam int MAX_A     = (1 << ADDR_W) - 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic              ub_n;
    logic              lb_n;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n, pace, flush;
  logic              fifo_empty = 1'b1;
  logic [7:0]        fifo_dout  = '0;
  logic              fifo_rd_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_o;
  logic              sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic              busy, wrap;
  logic [31:0]       words_written;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]        fifo_q[$];
  wr_t               exp_q[$];
  logic [7:0]        m_lo;
  bit                m_lo_valid = 0;
  logic [ADDR_W-1:0] m_addr  = '0;
  int                m_words = 0;
  int                m_wraps = 0;
  int                m_pops  = 0;

  // Monitor counters
  int rd_cnt   = 0;
  int wrap_cnt = 0;

  fifo_sram_writer #(
    .ADDR_W    (ADDR_W),
    .WE_CYCLES (WE_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pace          (pace),
    .flush         (flush),
    .fifo_empty    (fifo_empty),
    .fifo_dout     (fifo_dout),
    .fifo_rd_en    (fifo_rd_en),
    .sram_addr     (sram_addr),
    .sram_dq_o     (sram_dq_o),
    .sram_ce_n     (sram_ce_n),
    .sram_oe_n     (sram_oe_n),
    .sram_we_n     (sram_we_n),
    .sram_ub_n     (sram_ub_n),
    .sram_lb_n     (sram_lb_n),
    .busy          (busy),
    .wrap          (wrap),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: read data appears the cycle after the pop request.
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Model bookkeeping for one committed word.
  task automatic commit(input logic [15:0] data, input logic ub_n, input logic lb_n);
    exp_q.push_back('{m_addr, data, ub_n, lb_n});
    m_words++;
    if (m_addr == ADDR_W'(MAX_A)) begin
      m_addr = '0;
      m_wraps++;
    end else begin
      m_addr = m_addr + 1'b1;
    end
  endtask

  // Watch the DUT after a strobe issued on the preceding negedge.
  task automatic observe(input string name, input int exp_drop, input bit exp_rd, input int dup_at);
    int drop_at;
    bit act;
    drop_at = 0;
    act     = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({name, " rd_en"}, 32'(fifo_rd_en), 32'(exp_rd));
        pace  = 1'b0;
        flush = 1'b0;
      end
      if (busy || fifo_rd_en) act = 1'b1;
      if (exp_drop > 0 && drop_at == 0 && !busy) drop_at = k;
      if (dup_at > 0 && k == dup_at)     pace = 1'b1;
      if (dup_at > 0 && k == dup_at + 1) pace = 1'b0;
      if (exp_drop == 0 && k == 4) break;
      if (exp_drop > 0 && drop_at != 0 && k > dup_at) break;
    end
    if (exp_drop == 0) check({name, " no activity"}, 32'(act), 32'd0);
    else               check({name, " cycles to idle"}, drop_at, exp_drop);
    check({name, " words_written"}, words_written, m_words);
    check({name, " sram_addr"}, 32'(sram_addr), 32'(m_addr));
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // One pace pulse; dup_at > 0 raises pace again k cycles later while busy.
  task automatic pace_pulse(input string name, input int dup_at);
    bit   accepted, hi;
    logic [7:0] b;
    int   exp_drop;
    accepted = (fifo_q.size() != 0);
    hi       = m_lo_valid;
    exp_drop = 0;
    if (accepted) begin
      b = fifo_q[0];
      m_pops++;
      if (!m_lo_valid) begin
        m_lo       = b;
        m_lo_valid = 1'b1;
        exp_drop   = 3;
      end else begin
        commit({b, m_lo}, 1'b0, 1'b0);
        m_lo_valid = 1'b0;
        exp_drop   = 5 + WE_CYCLES;
      end
    end
    @(negedge clk);
    pace = 1'b1;
    observe(name, exp_drop, accepted, dup_at);
    if (!accepted && hi != m_lo_valid) check({name, " model"}, 0, 1);
  endtask

  task automatic flush_pulse(input string name);
    bit act;
    act = m_lo_valid;
    if (act) begin
      commit({8'h00, m_lo}, 1'b1, 1'b0);
      m_lo_valid = 1'b0;
    end
    @(negedge clk);
    flush = 1'b1;
    observe(name, act ? 3 + WE_CYCLES : 0, 1'b0, 0);
  endtask

  // SRAM bus monitor: completed writes are compared against the expected queue.
  bit                prev_we = 1'b1, prev_ce = 1'b1, in_wr = 1'b0, post_hold = 1'b0, stable;
  int                we_len;
  logic [ADDR_W-1:0] cap_addr;
  logic [15:0]       cap_dq;
  logic [1:0]        cap_lanes;
  wr_t               e;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_wr = 1'b0; prev_we = 1'b1; prev_ce = 1'b1; post_hold = 1'b0;
    end else begin
      if (fifo_rd_en) rd_cnt++;
      if (wrap) begin
        wrap_cnt++;
        check("address on wrap pulse", 32'(sram_addr), 32'd0);
      end
      if (post_hold) begin
        check("bus released after hold", {29'd0, sram_ce_n, sram_ub_n, sram_lb_n}, 32'd7);
        post_hold = 1'b0;
      end
      if (!sram_we_n && prev_we) begin
        in_wr = 1'b1; we_len = 1; stable = 1'b1;
        cap_addr = sram_addr; cap_dq = sram_dq_o; cap_lanes = {sram_ub_n, sram_lb_n};
        check("setup cycle before we_n", {30'd0, prev_ce, sram_ce_n}, 32'd0);
      end else if (!sram_we_n) begin
        we_len++;
        if (sram_addr !== cap_addr || sram_dq_o !== cap_dq || {sram_ub_n, sram_lb_n} !== cap_lanes)
          stable = 1'b0;
      end else if (!prev_we && in_wr) begin
        in_wr = 1'b0; post_hold = 1'b1;
        if (sram_addr !== cap_addr || sram_dq_o !== cap_dq || {sram_ub_n, sram_lb_n} !== cap_lanes)
          stable = 1'b0;
        check("we_n low cycles", we_len, WE_CYCLES);
        check("bus stable through hold", 32'(stable), 32'd1);
        check("ce_n/oe_n in hold", {30'd0, sram_ce_n, sram_oe_n}, 32'd1);
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected write: addr %0h data %0h", sram_addr, sram_dq_o);
        end else begin
          e = exp_q.pop_front();
          check("write address", 32'(cap_addr), 32'(e.addr));
          check("write data", 32'(cap_dq), 32'(e.data));
          check("write lanes ub_n/lb_n", 32'(cap_lanes), 32'({e.ub_n, e.lb_n}));
        end
      end
      prev_we = sram_we_n;
      prev_ce = sram_ce_n;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst_n = 1'b1; pace = 1'b1; flush = 1'b0;
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    #1 rst_n = 1'b0;
    #2;
    check("reset rd_en/busy/wrap", {29'd0, fifo_rd_en, busy, wrap}, 32'd0);
    check("reset sram controls", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1f);
    check("reset sram_addr", 32'(sram_addr), 32'd0);
    check("reset sram_dq_o", 32'(sram_dq_o), 32'd0);
    check("reset words_written", words_written, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // pace already high out of reset: no pop until it falls and rises again.
    repeat (4) @(negedge clk);
    check("no pop with pace high from reset", rd_cnt, 0);
    check("idle with pace high from reset", 32'(busy), 32'd0);
    pace = 1'b0;
    repeat (2) @(negedge clk);
    pace_pulse("pair 0x11", 0);
    pace_pulse("pair 0x22", 0);

    // Single byte committed by flush as a lower-lane write.
    fifo_q.push_back(8'hA5);
    pace_pulse("flush byte", 0);
    flush_pulse("flush commit");

    // Empty FIFO: pace edge must not pop; flush without a pending byte is idle.
    pace_pulse("empty pace", 0);
    flush_pulse("flush nothing pending");

    // Edges arriving while busy are discarded.
    repeat (3) fifo_q.push_back(8'($urandom_range(0, 255)));
    pace_pulse("edge during latch", 2);
    pace_pulse("edge during write", 5);
    check("fifo left after discarded edges", fifo_q.size(), 1);

    // Fill to cross the address wrap with random data.
    repeat (9) fifo_q.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 10; i++) pace_pulse("wrap sweep", 0);

    // Reset asserted mid-write: strobes release immediately, state clears.
    repeat (2) fifo_q.push_back(8'($urandom_range(0, 255)));
    pace_pulse("abort low byte", 0);
    m_pops++;
    @(negedge clk);
    pace = 1'b1;
    @(negedge clk);
    pace = 1'b0;
    k = 0;
    while (sram_we_n !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("we_n low before abort", 32'(sram_we_n), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async release we_n/ce_n", {30'd0, sram_we_n, sram_ce_n}, 32'd3);
    check("busy cleared by reset", 32'(busy), 32'd0);
    m_addr = '0; m_words = 0; m_lo_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-abort idle/addr", {31'd0, busy}, 32'd0);
    check("post-abort sram_addr", 32'(sram_addr), 32'd0);
    check("post-abort words_written", words_written, 32'd0);

    // Normal operation resumes at address 0.
    repeat (2) fifo_q.push_back(8'($urandom_range(0, 255)));
    pace_pulse("resume low", 0);
    pace_pulse("resume high", 0);

    repeat (4) @(negedge clk);
    check("expected writes all seen", exp_q.size(), 0);
    check("pops match accepted edges", rd_cnt, m_pops);
    check("wrap pulse count", wrap_cnt, m_wraps);
    check("fifo drained", fifo_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fifo_sram_writer
